ysyx_22040127_div_ctrl: RTL and testbench

Sequencer for the shared iterative 64-bit divide core in the EXU. Accepts RV64M divide/remainder requests over a valid/ready handshake, prepares operands (including 32-bit W variants), starts the core, applies RISC-V special-case results, and returns a 64-bit result. Sits between EXU issue and the divide core; it is the only block that drives the core's start and operands.

---
 rtl/ysyx_22040127_div_ctrl_pkg.sv | 23 ++
 rtl/ysyx_22040127_div_fix.sv | 72 +++++++
 rtl/ysyx_22040127_div_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22040127_div_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_div_ctrl_pkg.sv
// ysyx_22040127_div_ctrl_pkg
// Shared definitions for the divide sequencer: datapath width, RV64M
// divide op encoding and the controller state encoding.
package ysyx_22040127_div_ctrl_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_22040127_div_fix.sv
// ysyx_22040127_div_fix
// Combinational helper for the divide sequencer: operand preparation
// (W-variant sign/zero extension), special-case detection (divide by zero,
// signed overflow) and final result selection with special-case override
// and W-result sign extension.
// Ports:
//   i_op, i_word       operation and W flag
//   i_a, i_b           dividend / divisor (raw or already prepared)
//   i_quo, i_rem       core results (ignored when o_special)
//   o_x, o_y, o_s      prepared operands and signed flag
//   o_special          divisor zero or signed overflow
//   o_res              selected, overridden, width-adjusted result
module ysyx_22040127_div_fix
  import ysyx_22040127_div_ctrl_pkg::*;
(
  input  logic [1:0]      i_op,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_rem,
  output logic [XLEN-1:0] o_x,
  output logic [XLEN-1:0] o_y,
  output logic            o_s,
  output logic            o_special,
  output logic [XLEN-1:0] o_res
);

  logic            w_signed;
  logic            w_is_rem;
  logic            w_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_quo_sel;
  logic [XLEN-1:0] w_rem_sel;
  logic [XLEN-1:0] w_sel;

  assign w_signed = (i_op == OP_DIV) | (i_op == OP_REM);
  assign w_is_rem = (i_op == OP_REM) | (i_op == OP_REMU);

  // Preparation is idempotent, so the top can feed back the latched
  // prepared operands during BUSY and get the same special-case flags.
  always_comb begin
    o_x = i_a;
    o_y = i_b;
    if (i_word) begin
      if (w_signed) begin
        o_x = sext32(i_a[31:0]);
        o_y = sext32(i_b[31:0]);
      end else begin
        o_x = {{(XLEN-32){1'b0}}, i_a[31:0]};
        o_y = {{(XLEN-32){1'b0}}, i_b[31:0]};
      end
    end
  end

  assign o_s = w_signed;

  // Most-negative value of the active width, as it looks after preparation.
  assign w_min = i_word ? {{(XLEN-31){1'b1}}, 31'd0} : {1'b1, {(XLEN-1){1'b0}}};

  assign w_zero    = (o_y == '0);
  assign w_ovf     = w_signed & (o_y == '1) & (o_x == w_min);
  assign o_special = w_zero | w_ovf;

  assign w_quo_sel = w_zero ? '1  : (w_ovf ? o_x : i_quo);
  assign w_rem_sel = w_zero ? o_x : (w_ovf ? '0  : i_rem);
  assign w_sel     = w_is_rem ? w_rem_sel : w_quo_sel;

  assign o_res = i_word ? sext32(w_sel[31:0]) : w_sel;

endmodule

// File: rtl/ysyx_22040127_div_ctrl.sv
// ysyx_22040127_div_ctrl
// Sequencer for the shared iterative 64-bit divide core. Accepts RV64M
// divide/remainder requests, prepares operands, starts the core, applies
// RISC-V special-case results and returns a 64-bit result.
// Build option: DIV_CTRL_BYPASS_EN -- when defined, divide-by-zero and
// signed overflow are resolved here without starting the core.
// Ports:
//   clk, rst                       clock, async active-low reset
//   in_valid/in_ready, in_op,
//   in_word, in_a, in_b            request channel
//   out_valid/out_ready, out_res   response channel
//   flush                          kill in-flight or pending request
//   core_start, core_kill,
//   core_x, core_y, core_s         core control and operands
//   core_done, core_quo, core_rem  core completion and results
//
// state   | meaning
// IDLE    | ready for a request
// BUSY    | core running, waiting for core_done
// RESP    | result held on out_res until consumed
module ysyx_22040127_div_ctrl
  import ysyx_22040127_div_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  input  logic            flush,
  output logic            core_start,
  output logic            core_kill,
  output logic [XLEN-1:0] core_x,
  output logic [XLEN-1:0] core_y,
  output logic            core_s,
  input  logic            core_done,
  input  logic [XLEN-1:0] core_quo,
  input  logic [XLEN-1:0] core_rem
);

`ifdef DIV_CTRL_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [1:0]      r_op;
  logic            r_word;
  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;
  logic            r_s;
  logic [XLEN-1:0] r_res;
  logic            r_start;
  logic            r_kill;

  logic            w_idle;
  logic [1:0]      w_fix_op;
  logic            w_fix_word;
  logic [XLEN-1:0] w_fix_a;
  logic [XLEN-1:0] w_fix_b;
  logic [XLEN-1:0] w_x;
  logic [XLEN-1:0] w_y;
  logic            w_s;
  logic            w_special;
  logic [XLEN-1:0] w_res;
  logic            w_accept;
  logic            w_start_nxt;
  logic            w_kill_nxt;
  logic            w_load_res;

  // One helper serves both phases: raw request in IDLE, latched request
  // plus core results in BUSY.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_fix_op   = w_idle ? in_op   : r_op;
  assign w_fix_word = w_idle ? in_word : r_word;
  assign w_fix_a    = w_idle ? in_a    : r_x;
  assign w_fix_b    = w_idle ? in_b    : r_y;

  ysyx_22040127_div_fix u_fix (
    .i_op      (w_fix_op),
    .i_word    (w_fix_word),
    .i_a       (w_fix_a),
    .i_b       (w_fix_b),
    .i_quo     (core_quo),
    .i_rem     (core_rem),
    .o_x       (w_x),
    .o_y       (w_y),
    .o_s       (w_s),
    .o_special (w_special),
    .o_res     (w_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start_nxt = 1'b0;
    w_kill_nxt  = 1'b0;
    w_load_res  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          w_accept = 1'b1;
          if (BYPASS_EN && w_special) begin
            w_state_nxt = ST_RESP;
            w_load_res  = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
            w_start_nxt = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
          w_kill_nxt  = 1'b1;
        end else if (core_done) begin
          w_state_nxt = ST_RESP;
          w_load_res  = 1'b1;
        end
      end
      ST_RESP: begin
        if (flush || out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= OP_DIV;
      r_word  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= 1'b0;
      r_res   <= '0;
      r_start <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_start <= w_start_nxt;
      r_kill  <= w_kill_nxt;
      // Operands change only on accept, so they stay put for the whole
      // core run regardless of what the issue side drives meanwhile.
      if (w_accept) begin
        r_op   <= in_op;
        r_word <= in_word;
        r_x    <= w_x;
        r_y    <= w_y;
        r_s    <= w_s;
      end
      if (w_load_res) r_res <= w_res;
    end
  end

  assign in_ready   = w_idle;
  assign out_valid  = (r_state == ST_RESP);
  assign out_res    = r_res;
  assign core_start = r_start;
  assign core_kill  = r_kill;
  assign core_x     = r_x;
  assign core_y     = r_y;
  assign core_s     = r_s;

endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// tb_ysyx_22040127_div_ctrl
// Directed bench for the divide sequencer with a small behavioural core
// (fixed latency, garbage results on special cases so overrides show).
module tb_ysyx_22040127_div_ctrl;

`ifdef DIV_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic        in_word = 1'b0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic        flush = 1'b0;
  logic        core_start;
  logic        core_kill;
  logic [63:0] core_x;
  logic [63:0] core_y;
  logic        core_s;
  logic        core_done = 1'b0;
  logic [63:0] core_quo = '0;
  logic [63:0] core_rem = '0;

  logic        inj_done = 1'b0;
  int          core_cnt = 0;
  int          n_start = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  ysyx_22040127_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .flush      (flush),
    .core_start (core_start),
    .core_kill  (core_kill),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_s     (core_s),
    .core_done  (core_done),
    .core_quo   (core_quo),
    .core_rem   (core_rem)
  );

  always #5 clk = ~clk;

  // Behavioural divide core, updated on the falling edge.
  always @(negedge clk) begin
    core_done = inj_done;
    if (!rst) begin
      core_cnt = 0;
    end else if (core_kill) begin
      core_cnt = 0;
    end else if (core_start) begin
      n_start++;
      core_cnt = LAT;
      if (core_y == 64'd0 ||
          (core_s && core_x == 64'h8000_0000_0000_0000 && core_y == '1)) begin
        core_quo = 64'hDEAD_DEAD_DEAD_DEAD;
        core_rem = 64'hBEEF_BEEF_BEEF_BEEF;
      end else if (core_s) begin
        core_quo = $signed(core_x) / $signed(core_y);
        core_rem = $signed(core_x) % $signed(core_y);
      end else begin
        core_quo = core_x / core_y;
        core_rem = core_x % core_y;
      end
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) core_done = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request (entered on a falling edge), wait for the result,
  // optionally hold out_ready low for `hold` cycles, then consume it.
  task automatic run_req(input string tag, input logic [1:0] op, input logic word,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input bit spec, input int hold);
    int cyc;
    int s0;
    int exp_start;
    int exp_lat;
    exp_start = (BYP && spec) ? 0 : 1;
    exp_lat   = (BYP && spec) ? 1 : LAT + 2;
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    s0 = n_start;
    in_valid = 1'b1; in_op = op; in_word = word; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = '1; in_b = '1;
    check({tag, ".core_start"}, 64'(core_start), 64'(exp_start));
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".out_res"}, out_res, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_res"}, out_res, exp);
      check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ".starts"}, 64'(n_start - s0), 64'(exp_start));
  endtask

  initial begin
    int s0;
    #2;
    check("rst.in_ready",   64'(in_ready),   64'd1);
    check("rst.out_valid",  64'(out_valid),  64'd0);
    check("rst.out_res",    out_res,         64'd0);
    check("rst.core_start", 64'(core_start), 64'd0);
    check("rst.core_kill",  64'(core_kill),  64'd0);
    check("rst.core_x",     core_x,          64'd0);
    check("rst.core_y",     core_y,          64'd0);
    check("rst.core_s",     64'(core_s),     64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_req("div_m7_2",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
    run_req("rem_m7_2",  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_req("divu_7_0",  2'b01, 1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_req("remu_7_0",  2'b11, 1'b0, 64'd7, 64'd0, 64'd7, 1'b1, 0);
    run_req("div_ovf",   2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 0);
    run_req("rem_ovf",   2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    run_req("divw_ovf",  2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 0);
    run_req("divuw",     2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 1'b0, 0);
    run_req("remw_m7_2", 2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_req("remuw_0",   2'b11, 1'b1, 64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8765_4321, 1'b1, 0);
    run_req("divuw_hi",  2'b01, 1'b1, 64'hABCD_0000_0000_0064, 64'h1234_0000_0000_0007, 64'd14, 1'b0, 0);
    run_req("divu_hold", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 5);
    run_req("remu_after",2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 0);

    // flush two cycles after core_start, then a stray core_done
    s0 = n_start;
    in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush.core_start", 64'(core_start), 64'd1);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.core_kill", 64'(core_kill), 64'd1);
    check("flush.in_ready",  64'(in_ready),  64'd1);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    check("flush.kill_pulse", 64'(core_kill), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush.late_valid", 64'(out_valid), 64'd0);
      check("flush.late_ready", 64'(in_ready),  64'd1);
    end
    check("flush.starts", 64'(n_start - s0), 64'd1);

    // flush and in_valid together: nothing accepted
    s0 = n_start;
    in_valid = 1'b1; flush = 1'b1; in_op = 2'b01; in_a = 64'd100; in_b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flushacc.in_ready",   64'(in_ready),   64'd1);
    check("flushacc.core_start", 64'(core_start), 64'd0);
    @(negedge clk);
    check("flushacc.out_valid",  64'(out_valid),  64'd0);
    check("flushacc.starts",     64'(n_start - s0), 64'd0);

    // reset asserted mid-operation
    in_valid = 1'b1; in_op = 2'b00; in_word = 1'b0; in_a = 64'd100; in_b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst.busy_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    check("mrst.in_ready",   64'(in_ready),   64'd1);
    check("mrst.out_valid",  64'(out_valid),  64'd0);
    check("mrst.core_x",     core_x,          64'd0);
    check("mrst.core_y",     core_y,          64'd0);
    check("mrst.core_s",     64'(core_s),     64'd0);
    check("mrst.core_kill",  64'(core_kill),  64'd0);
    check("mrst.core_start", 64'(core_start), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst.kill_after", 64'(core_kill), 64'd0);
    run_req("post_rst", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
